// File: rtl/umi_reg_dev_pkg.sv
// Shared UMI definitions: opcodes, command field positions, error code and
// the response holding FSM state type.
package umi_reg_dev_pkg;

    localparam logic [4:0] UMI_REQ_READ   = 5'h01;
    localparam logic [4:0] UMI_RESP_READ  = 5'h02;
    localparam logic [4:0] UMI_REQ_WRITE  = 5'h03;
    localparam logic [4:0] UMI_RESP_WRITE = 5'h04;
    localparam logic [4:0] UMI_REQ_POSTED = 5'h05;

    localparam int UMI_OPCODE_LSB = 0;
    localparam int UMI_OPCODE_W   = 5;
    localparam int UMI_SIZE_LSB   = 5;
    localparam int UMI_SIZE_W     = 3;
    localparam int UMI_LEN_LSB    = 8;
    localparam int UMI_LEN_W      = 8;
    localparam int UMI_ERR_LSB    = 25;
    localparam int UMI_ERR_W      = 2;

    localparam logic [2:0] UMI_SIZE_WORD  = 3'd2;
    localparam logic [1:0] UMI_ERR_DEVERR = 2'b10;

    typedef enum logic {
        RESP_IDLE = 1'b0,
        RESP_PEND = 1'b1
    } resp_state_e;

endpackage

// File: rtl/umi_reg_dev_resp.sv
// Single-entry UMI response holding register. A load replaces the held
// response; without a load, a drained response empties the stage.
module umi_reg_dev_resp #(
    parameter int CW = 32,
    parameter int AW = 64,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          load,
    input  logic [CW-1:0] load_cmd,
    input  logic [AW-1:0] load_dstaddr,
    input  logic [AW-1:0] load_srcaddr,
    input  logic [DW-1:0] load_data,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [CW-1:0] resp_cmd,
    output logic [AW-1:0] resp_dstaddr,
    output logic [AW-1:0] resp_srcaddr,
    output logic [DW-1:0] resp_data
);
    import umi_reg_dev_pkg::*;

    resp_state_e state;

    // The parent only loads when the stage is empty or draining this cycle.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state        <= RESP_IDLE;
            resp_valid   <= 1'b0;
            resp_cmd     <= '0;
            resp_dstaddr <= '0;
            resp_srcaddr <= '0;
            resp_data    <= '0;
        end else begin
            if (load) begin
                state        <= RESP_PEND;
                resp_valid   <= 1'b1;
                resp_cmd     <= load_cmd;
                resp_dstaddr <= load_dstaddr;
                resp_srcaddr <= load_srcaddr;
                resp_data    <= load_data;
            end else if (state == RESP_PEND && resp_ready) begin
                state      <= RESP_IDLE;
                resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/umi_reg_dev.sv
// UMI register device: NREG 32-bit registers reachable through UMI
// read/write/posted requests, with a one-deep response stage.
module umi_reg_dev #(
    parameter int CW   = 32,
    parameter int AW   = 64,
    parameter int DW   = 32,
    parameter int NREG = 16
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               udev_req_valid,
    output logic               udev_req_ready,
    input  logic [CW-1:0]      udev_req_cmd,
    input  logic [AW-1:0]      udev_req_dstaddr,
    input  logic [AW-1:0]      udev_req_srcaddr,
    input  logic [DW-1:0]      udev_req_data,
    output logic               udev_resp_valid,
    input  logic               udev_resp_ready,
    output logic [CW-1:0]      udev_resp_cmd,
    output logic [AW-1:0]      udev_resp_dstaddr,
    output logic [AW-1:0]      udev_resp_srcaddr,
    output logic [DW-1:0]      udev_resp_data,
    output logic [NREG*32-1:0] reg_q,
    output logic [NREG-1:0]    reg_wr,
    output logic [15:0]        err_count
);
    import umi_reg_dev_pkg::*;

    localparam int LW = $clog2(NREG);

    logic                    accept;
    logic                    is_read;
    logic                    is_write;
    logic                    is_posted;
    logic                    addr_ok;
    logic                    bad;
    logic                    load;
    logic [UMI_OPCODE_W-1:0] opcode;
    logic [LW-1:0]           idx;
    logic [31:0]             rd_word;
    logic [CW-1:0]           rsp_cmd;
    logic [DW-1:0]           rsp_data;
    logic                    unused_bits;

    assign udev_req_ready = !udev_resp_valid || udev_resp_ready;
    assign accept         = udev_req_valid && udev_req_ready;

    assign opcode    = udev_req_cmd[UMI_OPCODE_LSB +: UMI_OPCODE_W];
    assign is_read   = (opcode == UMI_REQ_READ);
    assign is_write  = (opcode == UMI_REQ_WRITE);
    assign is_posted = (opcode == UMI_REQ_POSTED);

    // Only aligned single-word accesses that land inside the register window.
    assign idx     = udev_req_dstaddr[LW+1:2];
    assign addr_ok = (udev_req_dstaddr[1:0] == 2'b00)
                  && ((udev_req_dstaddr >> (LW + 2)) == '0)
                  && (udev_req_cmd[UMI_SIZE_LSB +: UMI_SIZE_W] == UMI_SIZE_WORD)
                  && (udev_req_cmd[UMI_LEN_LSB +: UMI_LEN_W] == '0);

    assign bad     = !(is_read || is_write || is_posted) || !addr_ok;
    assign load    = accept && (is_read || is_write);
    assign rd_word = reg_q[{idx, 5'b0} +: 32];

    assign unused_bits = ^{udev_req_cmd, udev_req_data};

    always_comb begin
        rsp_cmd = '0;
        rsp_cmd[UMI_OPCODE_LSB +: UMI_OPCODE_W] = is_read ? UMI_RESP_READ : UMI_RESP_WRITE;
        rsp_cmd[UMI_SIZE_LSB +: UMI_SIZE_W] = udev_req_cmd[UMI_SIZE_LSB +: UMI_SIZE_W];
        rsp_cmd[UMI_LEN_LSB +: UMI_LEN_W]   = udev_req_cmd[UMI_LEN_LSB +: UMI_LEN_W];
        if (!addr_ok) begin
            rsp_cmd[UMI_ERR_LSB +: UMI_ERR_W] = UMI_ERR_DEVERR;
        end
        rsp_data = '0;
        if (is_read && addr_ok) begin
            rsp_data[31:0] = rd_word;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            reg_q     <= '0;
            reg_wr    <= '0;
            err_count <= '0;
        end else begin
            reg_wr <= '0;
            if (accept && (is_write || is_posted) && addr_ok) begin
                reg_q[{idx, 5'b0} +: 32] <= udev_req_data[31:0];
                reg_wr[idx]              <= 1'b1;
            end
            if (accept && bad && err_count != 16'hFFFF) begin
                err_count <= err_count + 16'd1;
            end
        end
    end

    umi_reg_dev_resp #(
        .CW (CW),
        .AW (AW),
        .DW (DW)
    ) u_resp (
        .clk          (clk),
        .nreset       (nreset),
        .load         (load),
        .load_cmd     (rsp_cmd),
        .load_dstaddr (udev_req_srcaddr),
        .load_srcaddr (udev_req_dstaddr),
        .load_data    (rsp_data),
        .resp_valid   (udev_resp_valid),
        .resp_ready   (udev_resp_ready),
        .resp_cmd     (udev_resp_cmd),
        .resp_dstaddr (udev_resp_dstaddr),
        .resp_srcaddr (udev_resp_srcaddr),
        .resp_data    (udev_resp_data)
    );

endmodule

// File: tb/tb_umi_reg_dev.sv
// Bench for umi_reg_dev: vector table plus hand-written stall and reset
// sequences, responses checked against a scoreboard queue.
module tb_umi_reg_dev;

    logic         clk = 1'b0;
    logic         nreset;
    logic         udev_req_valid;
    logic         udev_req_ready;
    logic [31:0]  udev_req_cmd;
    logic [63:0]  udev_req_dstaddr;
    logic [63:0]  udev_req_srcaddr;
    logic [31:0]  udev_req_data;
    logic         udev_resp_valid;
    logic         udev_resp_ready;
    logic [31:0]  udev_resp_cmd;
    logic [63:0]  udev_resp_dstaddr;
    logic [63:0]  udev_resp_srcaddr;
    logic [31:0]  udev_resp_data;
    logic [511:0] reg_q;
    logic [15:0]  reg_wr;
    logic [15:0]  err_count;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [31:0] cmd;
        logic [63:0] dst;
        logic [63:0] src;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [31:0] cmd;
        logic [63:0] dst;
        logic [31:0] data;
        bit          resp;
        logic [31:0] rcmd;
        logic [31:0] rdata;
        logic [15:0] err;
    } vec_t;

    exp_t sbq[$];
    exp_t mon_e;
    vec_t vecs[13];

    umi_reg_dev #(.CW(32), .AW(64), .DW(32), .NREG(16)) dut (
        .clk               (clk),
        .nreset            (nreset),
        .udev_req_valid    (udev_req_valid),
        .udev_req_ready    (udev_req_ready),
        .udev_req_cmd      (udev_req_cmd),
        .udev_req_dstaddr  (udev_req_dstaddr),
        .udev_req_srcaddr  (udev_req_srcaddr),
        .udev_req_data     (udev_req_data),
        .udev_resp_valid   (udev_resp_valid),
        .udev_resp_ready   (udev_resp_ready),
        .udev_resp_cmd     (udev_resp_cmd),
        .udev_resp_dstaddr (udev_resp_dstaddr),
        .udev_resp_srcaddr (udev_resp_srcaddr),
        .udev_resp_data    (udev_resp_data),
        .reg_q             (reg_q),
        .reg_wr            (reg_wr),
        .err_count         (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_resp(input logic [31:0] cmd, input logic [63:0] dst,
                               input logic [63:0] src, input logic [31:0] data);
        exp_t e;
        e.cmd  = cmd;
        e.dst  = dst;
        e.src  = src;
        e.data = data;
        sbq.push_back(e);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [31:0] cmd, input logic [63:0] dst,
                        input logic [63:0] src, input logic [31:0] data);
        int n = 0;
        udev_req_valid   = 1'b1;
        udev_req_cmd     = cmd;
        udev_req_dstaddr = dst;
        udev_req_srcaddr = src;
        udev_req_data    = data;
        @(negedge clk);
        while (!udev_req_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) check("req_accept_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        udev_req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sbq.size() != 0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (sbq.size() != 0) begin
            check("resp_missing", 64'(sbq.size()), 64'd0);
            sbq.delete();
        end
    endtask

    always @(negedge clk) begin
        if (nreset && udev_resp_valid && udev_resp_ready) begin
            if (sbq.size() == 0) begin
                check("unexpected_resp", {63'd0, udev_resp_valid}, 64'd0);
            end else begin
                mon_e = sbq.pop_front();
                check("resp_cmd", udev_resp_cmd, mon_e.cmd);
                check("resp_dstaddr", udev_resp_dstaddr, mon_e.dst);
                check("resp_srcaddr", udev_resp_srcaddr, mon_e.src);
                if (mon_e.cmd[4:0] == 5'h02) check("resp_data", udev_resp_data, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //          cmd           dst      data          resp rcmd          rdata         err
        vecs[0]  = '{32'h00100041, 64'h8,  32'h0,        1'b1, 32'h00000042, 32'hDEADBEEF, 16'd0};
        vecs[1]  = '{32'h00000041, 64'h0,  32'h0,        1'b1, 32'h00000042, 32'h12345678, 16'd0};
        vecs[2]  = '{32'h00000041, 64'h2,  32'h0,        1'b1, 32'h04000042, 32'h0,        16'd1};
        vecs[3]  = '{32'h00000041, 64'h40, 32'h0,        1'b1, 32'h04000042, 32'h0,        16'd2};
        vecs[4]  = '{32'h00000043, 64'h44, 32'hFFFFFFFF, 1'b1, 32'h04000044, 32'h0,        16'd3};
        vecs[5]  = '{32'h00000041, 64'h4,  32'h0,        1'b1, 32'h00000042, 32'h0,        16'd3};
        vecs[6]  = '{32'h00000023, 64'h3C, 32'h77777777, 1'b1, 32'h04000024, 32'h0,        16'd4};
        vecs[7]  = '{32'h00000047, 64'h8,  32'h11111111, 1'b0, 32'h0,        32'h0,        16'd5};
        vecs[8]  = '{32'h00000143, 64'hC,  32'h22222222, 1'b1, 32'h04000144, 32'h0,        16'd6};
        vecs[9]  = '{32'h00000043, 64'h3C, 32'hA5A5A5A5, 1'b1, 32'h00000044, 32'h0,        16'd6};
        vecs[10] = '{32'h00000041, 64'h3C, 32'h0,        1'b1, 32'h00000042, 32'hA5A5A5A5, 16'd6};
        vecs[11] = '{32'h00000041, 64'h8,  32'h0,        1'b1, 32'h00000042, 32'hDEADBEEF, 16'd6};
        vecs[12] = '{32'h00000041, 64'hC,  32'h0,        1'b1, 32'h00000042, 32'h0,        16'd6};

        nreset           = 1'b0;
        udev_req_valid   = 1'b0;
        udev_req_cmd     = '0;
        udev_req_dstaddr = '0;
        udev_req_srcaddr = '0;
        udev_req_data    = '0;
        udev_resp_ready  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_resp_valid", {63'd0, udev_resp_valid}, 64'd0);
        check("rst_req_ready", {63'd0, udev_req_ready}, 64'd1);
        check("rst_reg_q", {63'd0, (reg_q != '0)}, 64'd0);
        check("rst_reg_wr", reg_wr, 64'd0);
        check("rst_err_count", err_count, 64'd0);
        @(posedge clk);
        #1;
        nreset = 1'b1;
        @(posedge clk);
        #1;

        // Write with one-cycle response latency and a single reg_wr pulse.
        expect_resp(32'h00000044, 64'h100, 64'h8, 32'h0);
        send(32'h00000043, 64'h8, 64'h100, 32'hDEADBEEF);
        @(negedge clk);
        check("wr_resp_latency", {63'd0, udev_resp_valid}, 64'd1);
        check("wr_reg_wr_pulse", reg_wr, 64'h0004);
        check("wr_reg_q2", reg_q[95:64], 64'hDEADBEEF);
        @(negedge clk);
        check("wr_reg_wr_end", reg_wr, 64'h0);
        wait_drain();

        // Posted write: register updated, no response.
        @(posedge clk);
        #1;
        send(32'h00000045, 64'h0, 64'h180, 32'h12345678);
        @(negedge clk);
        check("posted_resp_valid", {63'd0, udev_resp_valid}, 64'd0);
        check("posted_reg_wr", reg_wr, 64'h0001);
        check("posted_reg_q0", reg_q[31:0], 64'h12345678);
        @(negedge clk);
        check("posted_reg_wr_end", reg_wr, 64'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].resp)
                expect_resp(vecs[i].rcmd, 64'h200 + 64'(i), vecs[i].dst, vecs[i].rdata);
            send(vecs[i].cmd, vecs[i].dst, 64'h200 + 64'(i), vecs[i].data);
            wait_drain();
            repeat (2) @(negedge clk);
            check($sformatf("vec%0d_err_count", i), err_count, vecs[i].err);
            @(posedge clk);
            #1;
        end
        check("tbl_reg_q0", reg_q[31:0], 64'h12345678);
        check("tbl_reg_q1", reg_q[63:32], 64'h0);

        // Three reads against a stalled response port.
        expect_resp(32'h00000042, 64'h300, 64'h0, 32'h12345678);
        expect_resp(32'h00000042, 64'h301, 64'h8, 32'hDEADBEEF);
        expect_resp(32'h00000042, 64'h302, 64'h3C, 32'hA5A5A5A5);
        udev_resp_ready = 1'b0;
        fork
            begin
                send(32'h00000041, 64'h0, 64'h300, 32'h0);
                send(32'h00000041, 64'h8, 64'h301, 32'h0);
                send(32'h00000041, 64'h3C, 64'h302, 32'h0);
            end
            begin
                int n = 0;
                logic [31:0] c0;
                logic [31:0] d0;
                @(negedge clk);
                while (!udev_resp_valid && n < 20) begin
                    n++;
                    @(negedge clk);
                end
                c0 = udev_resp_cmd;
                d0 = udev_resp_data;
                check("stall_first_data", d0, 64'h12345678);
                repeat (5) begin
                    @(negedge clk);
                    check("stall_resp_valid", {63'd0, udev_resp_valid}, 64'd1);
                    check("stall_req_ready", {63'd0, udev_req_ready}, 64'd0);
                    check("stall_cmd_stable", udev_resp_cmd, c0);
                    check("stall_data_stable", udev_resp_data, d0);
                end
                @(posedge clk);
                #1;
                udev_resp_ready = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    check("b2b_resp_valid", {63'd0, udev_resp_valid}, 64'd1);
                end
            end
        join
        wait_drain();

        // Reset while a response is pending.
        @(posedge clk);
        #1;
        udev_resp_ready = 1'b0;
        send(32'h00000043, 64'h4, 64'h400, 32'h55555555);
        @(negedge clk);
        check("pre_rst_resp_valid", {63'd0, udev_resp_valid}, 64'd1);
        #2;
        nreset = 1'b0;
        #1;
        check("mid_rst_resp_valid", {63'd0, udev_resp_valid}, 64'd0);
        check("mid_rst_reg_q", {63'd0, (reg_q != '0)}, 64'd0);
        check("mid_rst_err_count", err_count, 64'd0);
        check("mid_rst_resp_cmd", udev_resp_cmd, 64'd0);
        @(posedge clk);
        #1;
        nreset = 1'b1;
        udev_resp_ready = 1'b1;
        @(negedge clk);
        check("post_rst_req_ready", {63'd0, udev_req_ready}, 64'd1);
        @(posedge clk);
        #1;
        expect_resp(32'h00000042, 64'h500, 64'h8, 32'h0);
        send(32'h00000041, 64'h8, 64'h500, 32'h0);
        wait_drain();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/umi_reg_dev.md
UMI_REG_DEV -- requirements
Module: umi_reg_dev

Interface
REQ-001: Parameter CW, default 32, UMI command width.
REQ-002: Parameter AW, default 64, UMI address width.
REQ-003: Parameter DW, default 32, UMI data width (≥32).
REQ-004: Parameter NREG, default 16, number of 32-bit registers (power of two, 2..256).
REQ-005: Port clk  input  1  sole clock.
REQ-006: Port nreset  input  1  asynchronous active-low reset.
REQ-007: Ports udev_req_valid/ready/cmd/dstaddr/srcaddr/data  in/out/in/in/in/in  1/1/CW/AW/AW/DW  UMI request sink, fed directly by umi_fifo_flex output.
REQ-008: Ports udev_resp_valid/ready/cmd/dstaddr/srcaddr/data  out/in/out/out/out/out  1/1/CW/AW/AW/DW  UMI response source, feeding the response umi_fifo_flex input.
REQ-009: Port reg_q  output  NREG*32  current register contents, register i at bits [32i+31:32i].
REQ-010: Port reg_wr  output  NREG  one-cycle pulse per register on each committed write.
REQ-011: Port err_count  output  16  saturating count of erroneous requests.

Function
REQ-012: Transfer occurs on a cycle where valid and ready are both high; valid, once asserted, holds with stable payload until accepted.
REQ-013: udev_req_ready = !resp_pending | udev_resp_ready, combinational, permitting one request per cycle at full throughput.
REQ-014: Opcode = cmd[4:0]; REQ_READ=0x01, REQ_WRITE=0x03, REQ_POSTED=0x05, RESP_READ=0x02, RESP_WRITE=0x04.
REQ-015: Index = dstaddr[2+log2(NREG)-1:2]; access valid iff dstaddr[1:0]=0, dstaddr bits above the index are zero, size cmd[7:5]=2, len cmd[15:8]=0.
REQ-016: Valid write/posted: register[index] <= data[31:0] at the acceptance edge; reg_wr[index] high for exactly the following cycle.
REQ-017: Valid read: response data = register[index] value sampled at acceptance, zero-extended to DW.
REQ-018: Invalid access: no register update, no reg_wr pulse, read data 0, response error field cmd[26:25]=2'b10, err_count increments.
REQ-019: Any other opcode: request accepted and dropped, no response, err_count increments.
REQ-020: READ/WRITE produce a response registered in the cycle after acceptance (latency 1); POSTED produces none.
REQ-021: Response cmd: opcode RESP_READ or RESP_WRITE, size/len copied from request, other fields zero except error field; resp dstaddr = req srcaddr, resp srcaddr = req dstaddr.
REQ-022: Response held stable while udev_resp_valid & !udev_resp_ready; new acceptance in the same cycle as response drain replaces it with no bubble.
REQ-023: err_count saturates at 0xFFFF.
REQ-024: Two-state response FSM: IDLE (no pending) -> PEND on READ/WRITE acceptance; PEND -> IDLE on drain without new READ/WRITE; PEND -> PEND on drain plus new READ/WRITE acceptance.

Reset
REQ-025: On nreset low, asynchronously: udev_resp_valid=0, all registers=0, reg_wr=0, err_count=0, FSM=IDLE; resp payload outputs 0.
REQ-026: Reset asserted mid-transaction discards the pending response; first post-reset cycle has udev_req_ready=1.

Structure
REQ-027: Opcode constants, cmd field offsets, and error code live in the shared UMI package, not in this module.
REQ-028: One sub-module natural: umi_reg_dev_resp, the single-entry response holding register with its valid/ready logic.

Verification
REQ-029: Write 0xDEADBEEF to 0x8 (REQ_WRITE, size 2, len 0, srcaddr 0x100) -> RESP_WRITE next cycle, dstaddr 0x100, srcaddr 0x8; reg_q[95:64]=0xDEADBEEF; reg_wr[2] one-cycle pulse.
REQ-030: Read 0x8 after REQ-029 -> RESP_READ, data 0xDEADBEEF, cmd[26:25]=0.
REQ-031: Posted write 0x12345678 to 0x0 -> no response, reg_q[31:0]=0x12345678, reg_wr[0] pulse.
REQ-032: Read 0x2 (misaligned), and read 0x40 with NREG=16 -> each RESP_READ with data 0, error 2'b10; err_count=2; no register changes.
REQ-033: Hold udev_resp_ready=0 for 5 cycles with 3 queued reads -> first response stable, udev_req_ready=0 during stall, then 3 responses back-to-back in order.
REQ-034: Assert nreset during pending response -> udev_resp_valid=0 immediately, reg_q=0, err_count=0.
